decode_sequencer: RTL

- Top-level sequencer for the image decompressor.
- Owns the single SRAM port and grants it to exactly one requester at a time: UART loader, milestone 2 (IDCT), or milestone 1 (upsample/colour-space conversion).
- Launches milestone 2 once, then launches milestone 1 once per image row, and counts rows to completion.
- A watchdog per launch detects a stalled milestone and parks the SRAM port safely.

---
 rtl/decode_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/decode_sequencer.sv
// Frame sequencer: UART load, IDCT, then one colour-conversion pass per row.
// Owns the SRAM port and parks it whenever no requester is granted.
module decode_sequencer #(
  parameter int ROWS           = 240,
  parameter bit M2_ENABLE      = 1'b1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        CLOCK_50_I,
  input  logic        Resetn,
  input  logic        start,
  input  logic        uart_done,
  input  logic [17:0] uart_address,
  input  logic [15:0] uart_write_data,
  input  logic        uart_we_n,
  output logic        m2_start,
  input  logic        m2_finish,
  input  logic [17:0] m2_address,
  input  logic [15:0] m2_write_data,
  input  logic        m2_we_n,
  output logic        m1_start,
  input  logic        m1_finish,
  input  logic [17:0] m1_address,
  input  logic [15:0] m1_write_data,
  input  logic        m1_we_n,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic [7:0]  row_index,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_M2_START,
    S_M2_RUN,
    S_M1_START,
    S_M1_RUN,
    S_ROW_NEXT,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [19:0] WD_LAST  = 20'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  ROW_LAST = 8'(ROWS - 1);

  state_t      state;
  state_t      state_n;
  logic [19:0] watchdog;
  logic        wd_expired;
  logic        run_st;
  logic        launch_st;
  logic        idle_n;

  assign wd_expired = (watchdog == WD_LAST);
  assign run_st     = (state == S_M2_RUN) || (state == S_M1_RUN);
  assign launch_st  = (state == S_M2_START) || (state == S_M1_START);
  assign idle_n     = (state_n == S_IDLE) || (state_n == S_DONE) ||
                      (state_n == S_ERROR);

  // Next-state selection; finish is checked before the watchdog.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_n = S_LOAD;
      end
      S_LOAD: begin
        if (uart_done)
          state_n = M2_ENABLE ? S_M2_START : S_M1_START;
      end
      S_M2_START: state_n = S_M2_RUN;
      S_M2_RUN: begin
        if (m2_finish)       state_n = S_M1_START;
        else if (wd_expired) state_n = S_ERROR;
      end
      S_M1_START: state_n = S_M1_RUN;
      S_M1_RUN: begin
        if (m1_finish)       state_n = S_ROW_NEXT;
        else if (wd_expired) state_n = S_ERROR;
      end
      S_ROW_NEXT: begin
        if (row_index == ROW_LAST) state_n = S_DONE;
        else                       state_n = S_M1_START;
      end
      S_DONE, S_ERROR: begin
        if (start) state_n = S_LOAD;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, launch pulses, status flags and row counter.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      state     <= S_IDLE;
      m2_start  <= 1'b0;
      m1_start  <= 1'b0;
      row_index <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state    <= state_n;
      m2_start <= (state == S_M2_START);
      m1_start <= (state == S_M1_START);
      busy     <= !idle_n;
      done     <= (state_n == S_DONE);
      error    <= (state_n == S_ERROR);
      if (state_n == S_LOAD)
        row_index <= 8'd0;
      else if (state == S_ROW_NEXT && state_n == S_M1_START)
        row_index <= row_index + 8'd1;
    end
  end

  // Per-launch watchdog: cleared on launch, counts RUN cycles, saturates.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn)
      watchdog <= 20'd0;
    else if (launch_st)
      watchdog <= 20'd0;
    else if (run_st && watchdog != '1)
      watchdog <= watchdog + 20'd1;
  end

  // SRAM grant decided by state alone; anything ungranted is parked.
  always_comb begin
    SRAM_address    = 18'd0;
    SRAM_write_data = 16'd0;
    SRAM_we_n       = 1'b1;
    unique case (state)
      S_LOAD: begin
        SRAM_address    = uart_address;
        SRAM_write_data = uart_write_data;
        SRAM_we_n       = uart_we_n;
      end
      S_M2_START, S_M2_RUN: begin
        SRAM_address    = m2_address;
        SRAM_write_data = m2_write_data;
        SRAM_we_n       = m2_we_n;
      end
      S_M1_START, S_M1_RUN: begin
        SRAM_address    = m1_address;
        SRAM_write_data = m1_write_data;
        SRAM_we_n       = m1_we_n;
      end
      default: begin
        SRAM_address    = 18'd0;
        SRAM_write_data = 16'd0;
        SRAM_we_n       = 1'b1;
      end
    endcase
  end

endmodule
